// File: rtl/cp_remover_if.sv
// Sample stream bundle for the cyclic-prefix remover.
// master drives din/valid/sof, slave returns the useful-sample stream.
interface cp_remover_if #(
  parameter int DATA_WIDTH = 13
);
  logic [DATA_WIDTH-1:0] din;
  logic                  valid;
  logic                  sof;
  logic [DATA_WIDTH-1:0] dout;
  logic                  dout_valid;
  logic                  sym_start;
  logic [7:0]            sym_cnt;
  logic                  err;

  modport master (
    output din, valid, sof,
    input  dout, dout_valid, sym_start, sym_cnt, err
  );

  modport slave (
    input  din, valid, sof,
    output dout, dout_valid, sym_start, sym_cnt, err
  );
endinterface

// File: rtl/cp_remover.sv
// OFDM cyclic-prefix remover: drops CP samples, forwards FFT_LEN per symbol.
// Define CP_REMOVER_ERR_EN to enable the sticky mid-frame resync error flag.
module cp_remover #(
  parameter int FFT_LEN    = 64,
  parameter int CP_LEN     = 16,
  parameter int NUM_SYM    = 4,
  parameter int DATA_WIDTH = 13
) (
  input  logic        clk,
  input  logic        rst,
  cp_remover_if.slave bus
);
  localparam int SYM_LEN = CP_LEN + FFT_LEN;
  localparam int CW      = $clog2(SYM_LEN);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SKIP_CP = 2'd1;
  localparam logic [1:0] PASS    = 2'd2;

  localparam logic [CW-1:0] CNT_LAST    = CW'(SYM_LEN - 1);
  localparam logic [CW-1:0] CNT_CP      = CW'(CP_LEN);
  localparam logic [CW-1:0] CNT_CP_LAST = CW'(CP_LEN - 1);
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);
  localparam logic [7:0]    SYM_LAST    = 8'(NUM_SYM - 1);

  // a one-sample CP is fully consumed by the sof sample itself
  localparam logic [1:0] ST_SOF = (CP_LEN == 1) ? PASS : SKIP_CP;

  logic [1:0]            state;
  logic [1:0]            state_n;
  logic [CW-1:0]         samp_cnt;
  logic [CW-1:0]         samp_cnt_n;
  logic [7:0]            sym_idx;
  logic [7:0]            sym_idx_n;
  logic                  fwd;
  logic                  last;

  logic [DATA_WIDTH-1:0] dout_q;
  logic                  dout_valid_q;
  logic                  sym_start_q;
  logic [7:0]            sym_cnt_q;

  assign last = (samp_cnt == CNT_LAST);

  // next-state and counter update; sof always restarts at symbol 0
  always_comb begin
    state_n    = state;
    samp_cnt_n = samp_cnt;
    sym_idx_n  = sym_idx;
    fwd        = 1'b0;
    if (bus.valid) begin
      if (bus.sof) begin
        state_n    = ST_SOF;
        samp_cnt_n = CNT_ONE;
        sym_idx_n  = 8'd0;
      end else begin
        unique case (state)
          SKIP_CP: begin
            samp_cnt_n = samp_cnt + CNT_ONE;
            if (samp_cnt == CNT_CP_LAST)
              state_n = PASS;
          end
          PASS: begin
            fwd = 1'b1;
            if (last) begin
              samp_cnt_n = '0;
              if (sym_idx == SYM_LAST) begin
                state_n   = IDLE;
                sym_idx_n = 8'd0;
              end else begin
                state_n   = SKIP_CP;
                sym_idx_n = sym_idx + 8'd1;
              end
            end else begin
              samp_cnt_n = samp_cnt + CNT_ONE;
            end
          end
          default: begin
            state_n = state;
          end
        endcase
      end
    end
  end

  // control state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      samp_cnt <= '0;
      sym_idx  <= 8'd0;
    end else begin
      state    <= state_n;
      samp_cnt <= samp_cnt_n;
      sym_idx  <= sym_idx_n;
    end
  end

  // one-stage output register; dout holds while no sample is forwarded
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      sym_start_q  <= 1'b0;
      sym_cnt_q    <= 8'd0;
    end else begin
      dout_valid_q <= fwd;
      sym_start_q  <= fwd && (samp_cnt == CNT_CP);
      if (fwd) begin
        dout_q    <= bus.din;
        sym_cnt_q <= sym_idx;
      end
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.sym_start  = sym_start_q;
  assign bus.sym_cnt    = sym_cnt_q;

`ifdef CP_REMOVER_ERR_EN
  logic resync;
  logic err_q;

  // sof landing exactly on the frame's final sample is a clean restart
  assign resync = bus.valid && bus.sof && (state != IDLE) &&
                  !((state == PASS) && last && (sym_idx == SYM_LAST));

  // sticky until reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err_q <= 1'b0;
    else if (resync)
      err_q <= 1'b1;
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_cp_remover.sv
// Directed-vector bench for cp_remover (default 64/16/4 configuration).
// Expected outputs come from frame-position arithmetic on din.
module tb_cp_remover;
  localparam int FFT_LEN = 64;
  localparam int CP_LEN  = 16;
  localparam int NUM_SYM = 4;
  localparam int DW      = 13;
  localparam int SYM     = CP_LEN + FFT_LEN;
  localparam int FRAME   = SYM * NUM_SYM;

  logic clk = 1'b0;
  logic rst = 1'b0;

  cp_remover_if #(.DATA_WIDTH(DW)) bus();

  cp_remover #(
    .FFT_LEN(FFT_LEN),
    .CP_LEN(CP_LEN),
    .NUM_SYM(NUM_SYM),
    .DATA_WIDTH(DW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_chk   = 0;
  int n_pass  = 0;
  int nxt     = -1;
  bit err_exp = 1'b0;
  int last_d  = 0;
  int dv_seen = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp)
      n_pass++;
    else
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
  endtask

  task automatic step(input int d, input bit v, input bit s);
    int p;
    bit ev;
    p = -1;
    if (v) begin
      if (s) begin
`ifdef CP_REMOVER_ERR_EN
        if (nxt >= 0 && nxt != FRAME - 1)
          err_exp = 1'b1;
`endif
        p = 0;
      end else begin
        p = nxt;
      end
      if (p >= 0)
        nxt = (p == FRAME - 1) ? -1 : p + 1;
    end
    ev = (p >= 0) && ((p % SYM) >= CP_LEN);
    bus.din   = DW'(d);
    bus.valid = v;
    bus.sof   = s;
    @(posedge clk);
    #1;
    if (bus.dout_valid)
      dv_seen++;
    check("dout_valid", int'(bus.dout_valid), int'(ev));
    if (ev) begin
      check("dout", int'(bus.dout), d);
      check("sym_start", int'(bus.sym_start), int'((p % SYM) == CP_LEN));
      check("sym_cnt", int'(bus.sym_cnt), p / SYM);
      last_d = d;
    end else begin
      check("dout_hold", int'(bus.dout), last_d);
    end
    check("err", int'(bus.err), int'(err_exp));
  endtask

  task automatic run(input int first, input int count,
                     input int sof_a, input int sof_b, input bit gaps);
    int i;
    int c;
    i = 0;
    c = 0;
    while (i < count) begin
      if (gaps && (c % 3 == 2)) begin
        step(8000, 1'b0, 1'b1);
      end else begin
        step(first + i, 1'b1,
             (first + i == sof_a) || (first + i == sof_b));
        i++;
      end
      c++;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_dout"}, int'(bus.dout), 0);
    check({tag, "_dv"}, int'(bus.dout_valid), 0);
    check({tag, "_ss"}, int'(bus.sym_start), 0);
    check({tag, "_sc"}, int'(bus.sym_cnt), 0);
    check({tag, "_err"}, int'(bus.err), 0);
  endtask

  initial begin
    bus.din   = '0;
    bus.valid = 1'b0;
    bus.sof   = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("rst0");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // plain frame, then stray samples in IDLE
    dv_seen = 0;
    run(0, FRAME, 0, -1, 1'b0);
    check("frame_dv_cnt", dv_seen, 256);
    dv_seen = 0;
    run(1000, 5, -1, -1, 1'b0);
    check("idle_dv_cnt", dv_seen, 0);

    // valid low every third cycle
    dv_seen = 0;
    run(0, FRAME, 0, -1, 1'b1);
    check("gap_dv_cnt", dv_seen, 256);

    // back-to-back frames, zero dead cycles
    dv_seen = 0;
    run(0, 2 * FRAME, 0, FRAME, 1'b0);
    check("b2b_dv_cnt", dv_seen, 512);
    check("b2b_err", int'(bus.err), 0);

    // sof on the very last sample of a frame
    dv_seen = 0;
    run(0, 2 * FRAME, 0, FRAME - 1, 1'b0);
    check("lastsof_dv_cnt", dv_seen, 511);
    check("lastsof_err", int'(bus.err), 0);

    // resync in symbol 1 PASS at din=100
    dv_seen = 0;
    run(0, 420, 0, 100, 1'b0);
    check("resync_dv_cnt", dv_seen, 324);
`ifdef CP_REMOVER_ERR_EN
    check("resync_err", int'(bus.err), 1);
`else
    check("resync_err", int'(bus.err), 0);
`endif

    // asynchronous reset mid-frame at din=150
    run(0, 151, 0, -1, 1'b0);
    check("pre_rst_dv", int'(bus.dout_valid), 1);
    rst = 1'b1;
    #1;
    check_reset_outputs("rst1");
    nxt     = -1;
    err_exp = 1'b0;
    last_d  = 0;
    #1 rst = 1'b0;
    dv_seen = 0;
    run(151, 20, -1, -1, 1'b0);
    check("post_rst_dv_cnt", dv_seen, 0);
    dv_seen = 0;
    run(0, FRAME, 0, -1, 1'b0);
    check("post_rst_frame_cnt", dv_seen, 256);
    check("post_rst_err", int'(bus.err), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
